// File: rtl/pac_wrr_sched.sv
// pac_wrr_sched: weighted round-robin grant scheduler for four requesters
// sharing one downstream sink. A tenure lasts as many whole transactions as
// the winner's weight, starving requesters are promoted by saturating age
// counters, and a beat-count cap bounds every tenure.
module pac_wrr_sched #(
  parameter int NREQ      = 4,
  parameter int WW        = 3,
  parameter int AGE_LIMIT = 8,
  parameter int LOCK_CAP  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_i,
  input  logic [NREQ*WW-1:0] weight_i,
  input  logic               beat_valid_i,
  input  logic               beat_ready_i,
  input  logic               last_i,
  output logic [3:0]         grant_o,
  output logic [1:0]         grant_idx_o,
  output logic               busy_o,
  output logic [3:0]         starve_o,
  output logic               lock_abort_o
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic [3:0] AGE_MAX = 4'd15;

  logic          state;
  logic [1:0]    ptr;
  logic [WW-1:0] credits;
  logic [7:0]    beat_cnt;
  logic          in_pkt;
  logic [3:0]    age [4];

  logic [3:0]    elig;
  logic [3:0]    starving;
  logic [1:0]    win_idx;
  logic [WW-1:0] win_weight;
  logic          decide;
  logic          fire;
  logic          cur_req;
  logic          rel_credit;
  logic          rel_drop;
  logic          rel_cap;
  logic          release_now;

  // Eligibility and starvation flags per requester; weight 0 masks a requester.
  always_comb begin
    elig     = '0;
    starving = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i]     = req_i[i] & (weight_i[i*WW +: WW] != '0);
      starving[i] = (age[i] >= 4'(AGE_LIMIT));
    end
  end

  // Winner search from ptr+1 around to ptr; a starving eligible requester
  // takes precedence over plain round-robin order.
  always_comb begin
    logic       found_starve;
    logic       found_any;
    logic [1:0] starve_idx;
    logic [1:0] any_idx;
    logic [1:0] cand;
    found_starve = 1'b0;
    found_any    = 1'b0;
    starve_idx   = ptr;
    any_idx      = ptr;
    cand         = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (elig[cand] && starving[cand] && !found_starve) begin
        found_starve = 1'b1;
        starve_idx   = cand;
      end
      if (elig[cand] && !found_any) begin
        found_any = 1'b1;
        any_idx   = cand;
      end
    end
    win_idx = found_starve ? starve_idx : any_idx;
  end

  // Weight of the selected winner, sampled only at the grant decision.
  always_comb begin
    win_weight = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == win_idx) begin
        win_weight = weight_i[i*WW +: WW];
      end
    end
  end

  // Release conditions evaluated during a tenure.
  always_comb begin
    decide      = (state == ST_IDLE) && (|elig);
    fire        = (state == ST_GRANT) && beat_valid_i && beat_ready_i;
    cur_req     = req_i[grant_idx_o];
    rel_credit  = fire && last_i && (credits == WW'(1));
    rel_drop    = (!cur_req && !in_pkt && !fire) || (fire && last_i && !cur_req);
    rel_cap     = fire && (({1'b0, beat_cnt} + 9'd1) == 9'(LOCK_CAP));
    release_now = (state == ST_GRANT) && (rel_credit || rel_drop || rel_cap);
  end

  // Grant FSM: IDLE decides a winner, GRANT holds until a release condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= 2'd3;
      grant_o     <= '0;
      grant_idx_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (decide) begin
            state       <= ST_GRANT;
            ptr         <= win_idx;
            grant_idx_o <= win_idx;
            grant_o     <= 4'b0001 << win_idx;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state   <= ST_IDLE;
            grant_o <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

  // Tenure bookkeeping: credits, beat count and mid-transaction flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits  <= '0;
      beat_cnt <= '0;
      in_pkt   <= 1'b0;
    end else if (decide) begin
      credits  <= win_weight;
      beat_cnt <= '0;
      in_pkt   <= 1'b0;
    end else if (fire) begin
      beat_cnt <= beat_cnt + 8'd1;
      if (last_i) begin
        in_pkt  <= 1'b0;
        credits <= credits - WW'(1);
      end else begin
        in_pkt <= 1'b1;
      end
    end
  end

  // Age counters change only at a grant decision: winner clears, other
  // eligible requesters saturate upward; ages persist across req drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        age[i] <= '0;
      end
    end else if (decide) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == win_idx) begin
          age[i] <= '0;
        end else if (elig[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + 4'd1;
        end
      end
    end
  end

  // One-cycle pulse whenever the beat cap forces the release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_abort_o <= 1'b0;
    end else begin
      lock_abort_o <= rel_cap;
    end
  end

  // Status outputs derived purely from registered state.
  always_comb begin
    busy_o   = (state == ST_GRANT);
    starve_o = starving;
  end

endmodule

// File: tb/tb_pac_wrr_sched.sv
// Directed bench for pac_wrr_sched: expected winners are queued as each
// scenario is set up and popped when a new grant appears.
module tb_pac_wrr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] weight;
  logic        bv;
  logic        br;
  logic        last;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [3:0]  starve;
  logic        lock_abort;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  logic [3:0] prev_grant = 4'b0000;

  pac_wrr_sched #(.NREQ(4), .WW(3), .AGE_LIMIT(2), .LOCK_CAP(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .weight_i     (weight),
    .beat_valid_i (bv),
    .beat_ready_i (br),
    .last_i       (last),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .busy_o       (busy),
    .starve_o     (starve),
    .lock_abort_o (lock_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    weight = '0;
    bv     = 1'b0;
    br     = 1'b0;
    last   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: each new grant must match the next queued winner.
  always @(negedge clk) begin
    int e;
    if (rst_n && (grant != 4'b0000) && (prev_grant == 4'b0000)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_grant", grant, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", grant, 32'(4'b0001 << e));
        chk("sb_idx", grant_idx, e);
      end
    end
    prev_grant = grant;
  end

  initial begin
    logic [3:0] wexp [7];
    int pulses;

    // Reset state
    rst_n = 1'b0; req = '0; weight = '0; bv = 0; br = 0; last = 0;
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_idx", grant_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_starve", starve, 0);
    chk("rst_lock", lock_abort, 0);

    // Fairness: all weights 1, single-beat transactions
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b1111; bv = 1; br = 1; last = 1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("fair_busy", busy, (i % 2 == 0) ? 1 : 0);
      if (i == 9) req = 4'b0000;
    end
    drain("fair_drain");

    // Weighting: w0=3, w1=1
    do_reset();
    weight = {3'd0, 3'd0, 3'd1, 3'd3};
    req = 4'b0011; bv = 1; br = 1; last = 1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    wexp = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("wt_grant", grant, wexp[i]);
      if (i == 6) req = 4'b0000;
    end
    drain("wt_drain");

    // Lock cap: requester 2 streams with last low
    do_reset();
    weight = {3'd1, 3'd7, 3'd0, 3'd0};
    req = 4'b1100; bv = 1; br = 1; last = 0;
    exp_q.push_back(2); exp_q.push_back(3);
    pulses = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (lock_abort) pulses++;
      if (i == 16) begin
        chk("lock_hold_grant", grant, 4'b0100);
        chk("lock_hold_pulse", lock_abort, 0);
      end
      if (i == 17) begin
        chk("lock_rel_grant", grant, 4'b0000);
        chk("lock_rel_pulse", lock_abort, 1);
      end
      if (i == 18) begin
        chk("lock_next_grant", grant, 4'b1000);
        chk("lock_next_pulse", lock_abort, 0);
      end
    end
    chk("lock_pulse_count", pulses, 1);
    bv = 0;
    drain("lock_drain");

    // Aging: requester 3 passed over twice, then beats RR order over 2
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b1011; bv = 1; br = 1; last = 1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    tick();
    chk("age_g1", grant, 4'b0001);
    chk("age_st_a", starve[3], 0);
    tick();
    chk("age_rel1", grant, 4'b0000);
    tick();
    chk("age_g2", grant, 4'b0010);
    chk("age_st_b", starve[3], 1);
    tick();
    chk("age_rel2", grant, 4'b0000);
    req = 4'b1111;
    tick();
    chk("age_g3", grant, 4'b1000);
    chk("age_st_c", starve[3], 0);
    req = 4'b0000;
    drain("age_drain");

    // Backpressure then early drop from requester 1 (weight 2)
    do_reset();
    weight = {3'd0, 3'd0, 3'd2, 3'd0};
    req = 4'b0010; bv = 0; br = 1; last = 0;
    exp_q.push_back(1);
    tick();
    chk("bp_grant", grant, 4'b0010);
    bv = 1;
    tick();
    chk("bp_busy", busy, 1);
    br = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_grant", grant, 4'b0010);
    end
    br = 1; last = 1;
    tick();
    chk("bp_after_pkt", grant, 4'b0010);
    bv = 0; last = 0; req = 4'b0000;
    tick();
    chk("drop_grant", grant, 4'b0000);
    chk("drop_busy", busy, 0);
    chk("drop_idx_hold", grant_idx, 1);
    drain("drop_drain");

    // Asynchronous reset mid-tenure
    do_reset();
    weight = {3'd0, 3'd1, 3'd0, 3'd0};
    req = 4'b0100; bv = 0; br = 1; last = 0;
    exp_q.push_back(2);
    tick();
    chk("arst_pre_grant", grant, 4'b0100);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_idx", grant_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lock", lock_abort, 0);
    chk("arst_starve", starve, 0);
    drain("arst_drain");

    // Masking: requester 0 weight 0 with req high
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd0};
    req = 4'b1111; bv = 1; br = 1; last = 1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mask_g0", grant[0], 0);
      if (i == 7) req = 4'b0000;
    end
    drain("mask_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pac_wrr_sched.md
# pac_wrr_sched

Weighted round-robin grant scheduler for the PAC-RR arbiter subsystem. It shares one downstream sink between four requesters. Each grant tenure lasts a number of whole transactions given by the winner's weight. Starving requesters are promoted by saturating age counters, and a beat-count lock cap guarantees that no tenure can hold the sink indefinitely. The grant control it drives (one-hot grant, index, busy) feeds the peripheral wrapper's status readback.

## Interface
- NREQ, 4: requester count; fixed at 4, index width 2.
- WW, 3: weight width per requester.
- AGE_LIMIT, 8: age value at which a requester counts as starving (1..15).
- LOCK_CAP, 16: maximum beats per tenure (1..255).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  4  per-requester request level.
- weight_i  in  12  weights; requester i at [3i+2:3i]. Weight 0 masks requester i.
- beat_valid_i  in  1  granted source presents a beat.
- beat_ready_i  in  1  sink accepts a beat.
- last_i  in  1  current beat ends a transaction.
- grant_o  out  4  registered one-hot grant.
- grant_idx_o  out  2  index of the current or last winner.
- busy_o  out  1  high while in GRANT.
- starve_o  out  4  bit i = age[i] >= AGE_LIMIT.
- lock_abort_o  out  1  one-cycle pulse when LOCK_CAP forces a release.

## Operation
- Eligibility: elig[i] = req_i[i] & (weight_i[i] != 0).
- fire = busy_o & beat_valid_i & beat_ready_i. Beats outside GRANT are ignored.
- State IDLE:
  - If any elig bit is set, choose a winner and go to GRANT.
  - Winner selection: search order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - The first starving eligible requester wins if any exists; otherwise the first eligible requester wins.
- On the grant decision:
  - ptr <= winner; grant_idx_o <= winner; grant_o <= onehot(winner).
  - credits <= weight_i[winner], sampled once. Weight changes mid-tenure have no effect.
  - beat_cnt <= 0; in_pkt <= 0; age[winner] <= 0.
  - Every other eligible requester's age increments, saturating at 15.
- State GRANT:
  - Each fire increments beat_cnt (8-bit).
  - A fire with last_i clears in_pkt and decrements credits. A fire without last_i sets in_pkt.
- Release from GRANT to IDLE (grant_o becomes 0 on the next edge) occurs on the first of these:
  - (a) a fire with last_i that brings credits to 0.
  - (b) req_i[winner]==0 while in_pkt==0 and no fire is in progress, or a fire with last_i while req_i[winner]==0.
  - (c) a fire that makes beat_cnt reach LOCK_CAP. This also pulses lock_abort_o for one cycle, even mid-transaction.
- If (a) and (c) occur together, lock_abort_o still pulses.
- grant_idx_o holds its value through IDLE.
- Non-winners' ages do not change during GRANT. A requester's age is retained across req deassertion.

## Timing
- Reset values: grant_o=0, grant_idx_o=0, busy_o=0, starve_o=0, lock_abort_o=0, ptr=3, ages=0, credits=0. The first arbitration after reset searches from requester 0.
- Grant latency: elig seen in IDLE at edge k gives grant_o valid after edge k. Latency is 1 cycle from a registered request.
- Release: the condition at edge k gives grant_o=0 after edge k. There is at least one IDLE cycle between tenures, so back-to-back tenures are spaced 1 cycle apart.
- All outputs are registered. There is no combinational path from req_i or beat_ready_i to any output.
- Asynchronous reset mid-tenure immediately clears all outputs and state. The sink sees no further grant.

## Test plan
- Fairness:
  - Stimulus: weights all 1, req_i=4'b1111, every beat with last_i=1, ready always high.
  - Required: grants in order 0,1,2,3,0, with one IDLE cycle between grants. busy_o toggles.
- Weighting:
  - Stimulus: weights {w0=3, w1=1}, req_i=4'b0011, single-beat transactions.
  - Required: grant_o=0001 for 3 fires, then 0010 for 1 fire, then 0001 again.
- Lock cap:
  - Stimulus: LOCK_CAP=16, weight 7, a 40-beat packet from requester 2 with last_i low.
  - Required: release after the 16th fire, lock_abort_o pulses exactly once, and the next eligible requester is granted.
- Aging:
  - Stimulus: AGE_LIMIT=2, requester 3 weight 0→1 while requesters 0 and 1 compete.
  - Required: starve_o[3] rises after 2 decisions that pass it over; requester 3 then wins ahead of RR order and starve_o[3] returns to 0.
- Early drop and backpressure:
  - Stimulus: requester 1 drops req between packets; beat_ready_i low for 5 cycles mid-packet.
  - Required: release on the cycle after the drop. No release and no credit change while stalled.
- Reset and masking:
  - Stimulus: assert rst_n low mid-tenure; separately, set weight 0 with req high.
  - Required: all outputs read 0 immediately on reset; the masked requester is never granted.
